// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the architectural PC, issues one instruction
// read at a time and presents {pc, instr, err} to decode through a one-entry register.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_err,
  output logic [1:0]  state
);

  // Handshakes: a request transfers when imem_req_valid & imem_req_ready; an output
  // entry transfers when if_valid & if_ready. Valid never depends on the matching
  // ready of the same channel, and valid/addr hold until accepted unless redirected.
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        slot_free;
  logic        aligned;
  logic        req_fire;

  assign slot_free      = !if_valid || if_ready;
  assign aligned        = (pc[1:0] == 2'b00);
  // Requests only go out when the output register can take the reply.
  assign imem_req_valid = !rst && (state == S_REQ) && slot_free && aligned;
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      state    <= S_REQ;
      if_valid <= 1'b0;
      if_pc    <= 32'd0;
      if_instr <= 32'd0;
      if_err   <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      if_valid <= 1'b0;
      // Any request still owed a response must have that response swallowed.
      case (state)
        S_REQ:          state <= req_fire ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state <= imem_resp_valid ? S_REQ : S_DROP;
        default:        state <= S_REQ;
      endcase
    end else begin
      if (if_valid && if_ready) if_valid <= 1'b0;
      case (state)
        S_REQ: begin
          if (req_fire) begin
            req_pc <= pc;
            state  <= S_WAIT;
          end else if (slot_free && !aligned) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_instr <= 32'd0;
            if_err   <= 1'b1;
            state    <= S_ERR;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if_valid <= 1'b1;
            if_pc    <= req_pc;
            if_instr <= imem_resp_data;
            if_err   <= 1'b0;
            pc       <= req_pc + 32'd4;
            state    <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_resp_valid) state <= S_REQ;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model with configurable latency, directed scenarios
// and a randomized run checked against a fetch-stream reference model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_err;
  logic [1:0]  fsm_state;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .if_err(if_err),
    .state(fsm_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 1;
  bit rnd_ready = 1'b0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_q[$];

  // Values captured at the falling edge of the most recent cycle
  logic        s_req_valid, s_req_ready, s_resp_valid, s_if_valid, s_if_err;
  logic        s_if_ready, s_redirect, s_rst;
  logic [31:0] s_addr, s_if_pc, s_if_instr, s_redirect_pc;
  logic [1:0]  s_state;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle: sample at negedge, then advance the memory model after posedge.
  task automatic tick();
    @(negedge clk);
    s_req_valid   = imem_req_valid;
    s_req_ready   = imem_req_ready;
    s_addr        = imem_addr;
    s_resp_valid  = imem_resp_valid;
    s_if_valid    = if_valid;
    s_if_pc       = if_pc;
    s_if_instr    = if_instr;
    s_if_err      = if_err;
    s_if_ready    = if_ready;
    s_state       = fsm_state;
    s_redirect    = redirect_valid;
    s_redirect_pc = redirect_pc;
    s_rst         = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (s_rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (s_resp_valid && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (s_req_valid && s_req_ready) begin
        pend_addr.push_back(s_addr);
        pend_due.push_back(cyc + lat - 1);
      end
    end
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    imem_req_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    rnd_ready = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (s_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %0b want 0", s_req_valid); end
    tests++; if (s_addr !== RST_PC) begin fails++; $display("FAIL reset_addr: got %h want %h", s_addr, RST_PC); end
    tests++; if (s_if_valid !== 1'b0) begin fails++; $display("FAIL reset_if_valid: got %0b want 0", s_if_valid); end
    tests++; if (s_if_pc !== 32'd0 || s_if_instr !== 32'd0 || s_if_err !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: got pc=%h instr=%h err=%0b want zeros", s_if_pc, s_if_instr, s_if_err);
    end
    tests++; if (s_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", s_state); end
  endtask

  task automatic test_sequential();
    logic [31:0] addr_q[$];
    logic [31:0] e;
    logic        ev;
    do_reset();
    lat = 1;
    exp_q = {32'h100, 32'h104, 32'h108};
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_req_valid && s_req_ready) addr_q.push_back(s_addr);
      ev = (i >= 2) && (i % 2 == 0);
      tests++; if (s_if_valid !== ev) begin fails++; $display("FAIL seq_if_valid cyc%0d: got %0b want %0b", i, s_if_valid, ev); end
      if (s_if_valid && s_if_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (s_if_pc !== e || s_if_instr !== mem_word(e) || s_if_err !== 1'b0) begin
          fails++; $display("FAIL seq_entry: got pc=%h instr=%h err=%0b want pc=%h instr=%h err=0",
                            s_if_pc, s_if_instr, s_if_err, e, mem_word(e));
        end
      end
    end
    tests++;
    if (addr_q.size() < 3) begin
      fails++; $display("FAIL seq_req_count: got %0d want >=3", addr_q.size());
    end else if (addr_q[0] !== 32'h100 || addr_q[1] !== 32'h104 || addr_q[2] !== 32'h108) begin
      fails++; $display("FAIL seq_addrs: got %h %h %h want 100 104 108", addr_q[0], addr_q[1], addr_q[2]);
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL seq_deliveries: %0d undelivered want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    int reqs = 0;
    do_reset();
    if_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i >= 2) begin
        if (s_req_valid) reqs++;
        tests++;
        if (s_if_valid !== 1'b1 || s_if_pc !== 32'h100) begin
          fails++; $display("FAIL stall_hold cyc%0d: got valid=%0b pc=%h want 1 100", i, s_if_valid, s_if_pc);
        end
      end
    end
    tests++; if (reqs != 0) begin fails++; $display("FAIL stall_no_req: got %0d requests want 0", reqs); end
    if_ready = 1'b1;
    tick();
    tests++;
    if (s_req_valid !== 1'b1 || s_addr !== 32'h104) begin
      fails++; $display("FAIL stall_release: got req=%0b addr=%h want 1 104", s_req_valid, s_addr);
    end
  endtask

  task automatic test_redirect_drop();
    bit got_req = 0, got_out = 0;
    logic [31:0] first_req = 32'd0, first_pc = 32'd0, first_instr = 32'd0;
    do_reset();
    lat = 4;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h2000;
    tick();
    redirect_valid = 1'b0;
    tick();
    tests++; if (s_state !== 2'd2 || s_req_valid !== 1'b0) begin
      fails++; $display("FAIL drop_state: got state=%0d req=%0b want 2 0", s_state, s_req_valid);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!got_req && s_req_valid && s_req_ready) begin got_req = 1; first_req = s_addr; end
      if (!got_out && s_if_valid) begin got_out = 1; first_pc = s_if_pc; first_instr = s_if_instr; end
    end
    tests++; if (!got_req || first_req !== 32'h2000) begin fails++; $display("FAIL drop_next_req: got %h (seen=%0b) want 2000", first_req, got_req); end
    tests++; if (!got_out || first_pc !== 32'h2000 || first_instr !== mem_word(32'h2000)) begin
      fails++; $display("FAIL drop_first_out: got pc=%h instr=%h (seen=%0b) want pc=2000 instr=%h", first_pc, first_instr, got_out, mem_word(32'h2000));
    end
    lat = 1;
  endtask

  task automatic test_redirect_flush();
    bit got_out = 0;
    logic [31:0] first_pc = 32'd0;
    do_reset();
    lat = 1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    tick();
    tests++; if (s_resp_valid !== 1'b1) begin fails++; $display("FAIL flush_resp_present: got %0b want 1", s_resp_valid); end
    redirect_valid = 1'b0;
    tick();
    tests++; if (s_if_valid !== 1'b0 || s_state !== 2'd0 || s_req_valid !== 1'b1 || s_addr !== 32'h400) begin
      fails++; $display("FAIL flush_discard: got valid=%0b state=%0d req=%0b addr=%h want 0 0 1 400", s_if_valid, s_state, s_req_valid, s_addr);
    end
    if_ready = 1'b0;
    tick();
    tick();
    tests++; if (s_if_valid !== 1'b1 || s_if_pc !== 32'h400) begin
      fails++; $display("FAIL flush_load: got valid=%0b pc=%h want 1 400", s_if_valid, s_if_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h600;
    tick();
    redirect_valid = 1'b0;
    tick();
    tests++; if (s_if_valid !== 1'b0 || s_state !== 2'd0 || s_addr !== 32'h600 || s_req_valid !== 1'b1) begin
      fails++; $display("FAIL flush_output: got valid=%0b state=%0d req=%0b addr=%h want 0 0 1 600", s_if_valid, s_state, s_req_valid, s_addr);
    end
    if_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!got_out && s_if_valid) begin got_out = 1; first_pc = s_if_pc; end
    end
    tests++; if (!got_out || first_pc !== 32'h600) begin fails++; $display("FAIL flush_first_out: got %h (seen=%0b) want 600", first_pc, got_out); end
  endtask

  task automatic test_misaligned();
    int reqs = 0;
    bit got_req = 0;
    logic [31:0] first_req = 32'd0;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h402;
    tick();
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    tick();
    tests++; if (s_req_valid !== 1'b0) begin fails++; $display("FAIL mis_no_req: got %0b want 0", s_req_valid); end
    tick();
    tests++; if (s_if_valid !== 1'b1 || s_if_pc !== 32'h402 || s_if_err !== 1'b1 || s_if_instr !== 32'd0 || s_state !== 2'd3) begin
      fails++; $display("FAIL mis_entry: got valid=%0b pc=%h err=%0b instr=%h state=%0d want 1 402 1 0 3",
                        s_if_valid, s_if_pc, s_if_err, s_if_instr, s_state);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_req_valid) reqs++;
    end
    tests++; if (reqs != 0 || s_state !== 2'd3 || s_if_valid !== 1'b1) begin
      fails++; $display("FAIL mis_hold: got reqs=%0d state=%0d valid=%0b want 0 3 1", reqs, s_state, s_if_valid);
    end
    if_ready = 1'b1;
    tick();
    tick();
    tests++; if (s_if_valid !== 1'b0 || s_state !== 2'd3 || s_req_valid !== 1'b0) begin
      fails++; $display("FAIL mis_idle: got valid=%0b state=%0d req=%0b want 0 3 0", s_if_valid, s_state, s_req_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h500;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!got_req && s_req_valid && s_req_ready) begin got_req = 1; first_req = s_addr; end
    end
    tests++; if (!got_req || first_req !== 32'h500) begin fails++; $display("FAIL mis_resume: got %h (seen=%0b) want 500", first_req, got_req); end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] addr_q[$];
    bit got_out = 0, fired = 0;
    logic [31:0] first_pc = 32'd0;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_req_valid && s_req_ready) addr_q.push_back(s_addr);
      if (!got_out && s_if_valid) begin got_out = 1; first_pc = s_if_pc; end
    end
    tests++;
    if (addr_q.size() < 2) begin
      fails++; $display("FAIL wrap_req_count: got %0d want >=2", addr_q.size());
    end else if (addr_q[0] !== 32'hFFFF_FFFC || addr_q[1] !== 32'h0) begin
      fails++; $display("FAIL wrap_addrs: got %h %h want fffffffc 00000000", addr_q[0], addr_q[1]);
    end
    tests++; if (!got_out || first_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_first_out: got %h want fffffffc", first_pc); end
    lat = 4;
    for (int i = 0; i < 10 && !fired; i++) begin
      tick();
      fired = s_req_valid && s_req_ready;
    end
    tests++; if (!fired) begin fails++; $display("FAIL rst_wait_setup: got no request in 10 cycles want 1"); end
    rst = 1'b1;
    tick();
    tests++; if (s_state !== 2'd1) begin fails++; $display("FAIL rst_in_wait: got state=%0d want 1", s_state); end
    rst = 1'b0;
    tick();
    tests++; if (s_if_valid !== 1'b0 || s_state !== 2'd0 || s_addr !== RST_PC) begin
      fails++; $display("FAIL rst_mid_op: got valid=%0b state=%0d addr=%h want 0 0 %h", s_if_valid, s_state, s_addr, RST_PC);
    end
    lat = 1;
  endtask

  // Reference: requests walk sequentially from the last redirect target, and decode
  // sees the same sequential stream; a misaligned PC yields one error entry.
  task automatic test_random();
    logic [31:0] exp_req = RST_PC, exp_out = RST_PC;
    bit p_valid = 0, p_ready = 0, p_redir = 0, have_prev = 0;
    logic [31:0] p_addr = 32'd0;
    logic        mis;
    int delivered = 0;
    do_reset();
    rnd_ready = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 4);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = 32'h1000 + {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 5) == 0) redirect_pc = redirect_pc | $urandom_range(1, 3);
      tick();
      if (have_prev && p_valid && !p_ready && !p_redir) begin
        tests++;
        if (s_req_valid !== 1'b1 || s_addr !== p_addr) begin
          fails++; $display("FAIL rnd_req_hold: got req=%0b addr=%h want 1 %h", s_req_valid, s_addr, p_addr);
        end
      end
      if (s_redirect) begin
        exp_req = s_redirect_pc;
        exp_out = s_redirect_pc;
      end else begin
        if (s_req_valid && s_req_ready) begin
          tests++;
          if (s_addr !== exp_req) begin fails++; $display("FAIL rnd_req_addr: got %h want %h", s_addr, exp_req); end
          exp_req = exp_req + 32'd4;
        end
        if (s_if_valid && s_if_ready) begin
          mis = (exp_out[1:0] != 2'b00);
          tests++;
          if (s_if_pc !== exp_out || s_if_err !== mis || s_if_instr !== (mis ? 32'd0 : mem_word(exp_out))) begin
            fails++; $display("FAIL rnd_entry: got pc=%h instr=%h err=%0b want pc=%h instr=%h err=%0b",
                              s_if_pc, s_if_instr, s_if_err, exp_out, mis ? 32'd0 : mem_word(exp_out), mis);
          end
          if (!mis) exp_out = exp_out + 32'd4;
          delivered++;
        end
      end
      p_valid = s_req_valid; p_ready = s_req_ready; p_redir = s_redirect; p_addr = s_addr;
      have_prev = 1;
    end
    redirect_valid = 1'b0;
    rnd_ready = 1'b0;
    lat = 1;
    tests++; if (delivered < 20) begin fails++; $display("FAIL rnd_progress: got %0d deliveries want >=20", delivered); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drop();
    test_redirect_flush();
    test_misaligned();
    test_wrap_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
